alu_arbiter: RTL and testbench

Shares the single add/subtract ALU between two requesters, such as the instruction-execute path and the I/O transfer engine. The block uses a round-robin arbiter with a valid/ready request handshake. It drives the ALU operand and opcode inputs from registers and captures the ALU result and flags one cycle later. It returns them on a registered response channel with back-pressure. It sits between the requesters and the ALU instance. The ALU itself stays purely combinational.

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational add/subtract ALU between two requesters.
//   A round-robin arbiter accepts one request at a time over a valid/ready
//   handshake. It registers the operands and opcode toward the ALU and
//   captures the result and flags one cycle later. The captured values are
//   returned on a registered response channel that supports back-pressure.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   reqN_valid / reqN_ready     request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op     operands and opcode (0 = add, 1 = subtract)
//   alu_in_A, alu_in_B, alu_op  registered operands and opcode to the ALU
//   alu_out, alu_flag_n/z       result and negative/zero flags from the ALU
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_data, rsp_n/z   captured requester index, result and flags
module alu_arbiter #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_op,
    output logic [DATA_W-1:0] alu_in_A,
    output logic [DATA_W-1:0] alu_in_B,
    output logic              alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_flag_n,
    input  logic              alu_flag_z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_n,
    output logic              rsp_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic last_grant;
    logic id_q;
    logic win_valid;
    logic win_id;
    logic accept;

    // Winner selection: a lone requester wins outright; under contention the
    // requester that was not granted last time wins.
    always_comb begin
        win_valid = req0_valid | req1_valid;
        win_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            win_id = ~last_grant;
        end else if (req1_valid) begin
            win_id = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = EXEC;
            EXEC:                   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output logic. The ready outputs are gated with reset so that they stay
    // low while reset is held, even though the state already reads IDLE.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && !reset && win_valid) begin
            req0_ready = ~win_id;
            req1_ready = win_id;
        end
        accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // Operand, grant and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_in_A   <= '0;
            alu_in_B   <= '0;
            alu_op     <= 1'b0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
        end else begin
            if (accept) begin
                alu_in_A   <= win_id ? req1_a  : req0_a;
                alu_in_B   <= win_id ? req1_b  : req0_b;
                alu_op     <= win_id ? req1_op : req0_op;
                id_q       <= win_id;
                last_grant <= win_id;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_out;
                rsp_n     <= alu_flag_n;
                rsp_z     <= alu_flag_z;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready, req0_op;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic              req1_valid, req1_ready, req1_op;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [DATA_W-1:0] alu_in_A, alu_in_B, alu_out;
    logic              alu_op, alu_flag_n, alu_flag_z;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_n, rsp_z;
    logic [DATA_W-1:0] rsp_data;

    int vectors    = 0;
    int miscompares = 0;

    // Combinational ALU the block is meant to drive
    assign alu_out    = alu_op ? (alu_in_A - alu_in_B) : (alu_in_A + alu_in_B);
    assign alu_flag_n = alu_out[DATA_W-1];
    assign alu_flag_z = (alu_out == '0);

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_in_A   (alu_in_A),
        .alu_in_B   (alu_in_B),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_flag_n (alu_flag_n),
        .alu_flag_z (alu_flag_z),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction from a single requester with rsp_ready high.
    // Called with the block in IDLE, one time unit after a rising edge.
    task automatic run_op(input string tag, input logic idx, input logic [15:0] a,
                          input logic [15:0] b, input logic op, input logic [15:0] ed,
                          input logic en, input logic ez);
        rsp_ready = 1'b1;
        if (idx) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        #1;
        chk({tag, ".ready0"}, req0_ready, !idx);
        chk({tag, ".ready1"}, req1_ready, idx);
        tick();                                   // accept edge N
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tag, ".alu_a"}, alu_in_A, a);
        chk({tag, ".alu_b"}, alu_in_B, b);
        chk({tag, ".alu_op"}, alu_op, op);
        chk({tag, ".exec_valid"}, rsp_valid, 0);
        chk({tag, ".exec_rdy"}, {req0_ready, req1_ready}, 0);
        tick();                                   // edge N+1
        chk({tag, ".rsp_valid"}, rsp_valid, 1);
        chk({tag, ".rsp_data"}, rsp_data, ed);
        chk({tag, ".rsp_id"}, rsp_id, idx);
        chk({tag, ".rsp_n"}, rsp_n, en);
        chk({tag, ".rsp_z"}, rsp_z, ez);
        tick();                                   // edge N+2, consumed
        chk({tag, ".done_valid"}, rsp_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();

        // Reset values, with a request present to show ready stays low
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.rsp_id", rsp_id, 0);
        chk("rst.rsp_data", rsp_data, 0);
        chk("rst.rsp_nz", {rsp_n, rsp_z}, 0);
        chk("rst.alu_a", alu_in_A, 0);
        chk("rst.alu_b", alu_in_B, 0);
        chk("rst.alu_op", alu_op, 0);
        chk("rst.ready", {req0_ready, req1_ready}, 0);

        reset = 1'b0;
        req0_valid = 1'b0;
        tick();

        // Directed arithmetic and flag vectors
        run_op("add",  1'b0, 16'd5, 16'd3, 1'b0, 16'h0008, 1'b0, 1'b0);
        run_op("sub",  1'b1, 16'd3, 16'd5, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        run_op("subz", 1'b1, 16'd7, 16'd7, 1'b1, 16'h0000, 1'b0, 1'b1);
        run_op("wrap", 1'b1, 16'hFFFF, 16'd1, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Round-robin under continuous contention; last grant was requester 1
        req0_a = 16'd1;  req0_b = 16'd2; req0_op = 1'b0;
        req1_a = 16'd10; req1_b = 16'd4; req1_op = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int unsigned k = 0; k < 4; k++) begin
            chk("rr.ready0", req0_ready, (k % 2 == 0));
            chk("rr.ready1", req1_ready, (k % 2 == 1));
            tick();
            chk("rr.alu_a", alu_in_A, (k % 2 == 0) ? 16'd1 : 16'd10);
            chk("rr.exec_rdy", {req0_ready, req1_ready}, 0);
            tick();
            chk("rr.rsp_id", rsp_id, k % 2);
            chk("rr.rsp_data", rsp_data, (k % 2 == 0) ? 16'd3 : 16'd6);
            tick();
            chk("rr.done_valid", rsp_valid, 0);
        end

        // Back-pressure: requester 0 wins (last grant was 1), consumer stalls
        req0_a = 16'd100; req0_b = 16'd1; req0_op = 1'b1;
        rsp_ready = 1'b0;
        #1;
        chk("bp.ready0", req0_ready, 1);
        tick();
        req0_a = 16'h1234;
        tick();
        chk("bp.rsp_valid", rsp_valid, 1);
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            chk("bp.hold_valid", rsp_valid, 1);
            chk("bp.hold_data", rsp_data, 16'd99);
            chk("bp.hold_id", rsp_id, 0);
            chk("bp.hold_nz", {rsp_n, rsp_z}, 0);
            chk("bp.hold_rdy", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp.release_valid", rsp_valid, 0);
        chk("bp.next_ready1", req1_ready, 1);
        chk("bp.next_ready0", req0_ready, 0);
        tick();
        chk("bp.next_alu_a", alu_in_A, 16'd10);
        tick();
        chk("bp.next_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 16'd6});
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Reset during EXEC after a requester-0 grant
        req0_a = 16'h8000; req0_b = 16'd0; req0_op = 1'b0;
        req0_valid = 1'b1;
        tick();
        chk("mid.alu_a", alu_in_A, 16'h8000);
        reset = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mid.rst_alu_a", alu_in_A, 0);
        chk("mid.rst_rsp_valid", rsp_valid, 0);
        chk("mid.rst_ready", {req0_ready, req1_ready}, 0);
        tick();
        chk("mid.rst_hold_valid", rsp_valid, 0);
        chk("mid.rst_hold_data", rsp_data, 0);
        reset = 1'b0;
        #1;
        chk("mid.first_ready0", req0_ready, 1);
        chk("mid.first_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("mid.alu_a2", alu_in_A, 16'h8000);
        tick();
        chk("mid.rsp", {rsp_valid, rsp_id, rsp_n, rsp_z, rsp_data},
            {1'b1, 1'b0, 1'b1, 1'b0, 16'h8000});
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
